// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter/sequencer for the 8-to-1 datapath mux: drives {S2,S1,S0}, one-hot Grant, captures MuxY beats.
// Build option: define ARB_TURNAROUND_EN to insert one dead bus cycle (TURN) after every grant release.
module mux_bus_arbiter #(
    parameter int WIDTH    = 16,
    parameter int HOLD_MAX = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [7:0]       Req,
    input  logic [WIDTH-1:0] MuxY,
    output logic             S2,
    output logic             S1,
    output logic             S0,
    output logic [7:0]       Grant,
    output logic [WIDTH-1:0] DataOut,
    output logic             DataValid,
    output logic             Busy
);

`ifdef ARB_TURNAROUND_EN
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_GRANT} state_t;
`endif

    state_t     state;
    logic [2:0] sel;
    logic [2:0] ptr;
    logic [3:0] beatcnt;
    logic       beat;
    logic       last_beat;
    logic       release_now;
    logic       arb_now;
    logic [3:0] pick;

    // Returns {found, index}: first set request searching ptr+1, ptr+2, ... ptr+8 (mod 8).
    function automatic logic [3:0] rr_pick(input logic [7:0] rq, input logic [2:0] p);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'b0;
        for (int k = 8; k >= 1; k--) begin
            idx = p + 3'(k);
            if (rq[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    // While granted, sel holds the granted index and ptr equals it, so the
    // current owner is searched last and only wins again when it is alone.
    assign pick        = rr_pick(Req, ptr);
    assign beat        = (state == ST_GRANT) && Req[sel];
    assign last_beat   = beat && (beatcnt == 4'(HOLD_MAX - 1));
    assign release_now = (state == ST_GRANT) && (!Req[sel] || last_beat);

`ifdef ARB_TURNAROUND_EN
    assign arb_now = (state == ST_IDLE) || (state == ST_TURN);
`else
    assign arb_now = (state == ST_IDLE) || release_now;
`endif

    assign {S2, S1, S0} = sel;
    assign Busy         = (state != ST_IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            Grant     <= 8'h00;
            sel       <= 3'd0;
            ptr       <= 3'd7;
            beatcnt   <= 4'd0;
            DataOut   <= '0;
            DataValid <= 1'b0;
        end else begin
            DataValid <= beat;
            if (beat) begin
                DataOut <= MuxY;
                beatcnt <= beatcnt + 4'd1;
            end
            if (arb_now) begin
                if (pick[3]) begin
                    state   <= ST_GRANT;
                    Grant   <= 8'd1 << pick[2:0];
                    sel     <= pick[2:0];
                    ptr     <= pick[2:0];
                    beatcnt <= 4'd0;
                end else begin
                    state <= ST_IDLE;
                    Grant <= 8'h00;
                end
            end
`ifdef ARB_TURNAROUND_EN
            else if (release_now) begin
                state <= ST_TURN;
                Grant <= 8'h00;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Scoreboard bench for mux_bus_arbiter; expectations follow ARB_TURNAROUND_EN when it is defined.
module tb_mux_bus_arbiter;
    localparam int W = 16;
    localparam int H = 4;
`ifdef ARB_TURNAROUND_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif
    localparam int P = H + GAP;

    typedef struct packed {
        logic [7:0]   g;
        logic         v;
        logic [W-1:0] d;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   req;
    logic [W-1:0] muxy;
    logic         s2, s1, s0;
    logic [7:0]   grant;
    logic [W-1:0] dout;
    logic         dv;
    logic         busy;

    exp_t sbq[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ord[8];
    int   ord_len;

    always #5 clk = ~clk;

    mux_bus_arbiter #(.WIDTH(W), .HOLD_MAX(H)) dut (
        .Clk(clk), .Reset_n(rst_n), .Req(req), .MuxY(muxy),
        .S2(s2), .S1(s1), .S0(s0), .Grant(grant),
        .DataOut(dout), .DataValid(dv), .Busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
        return r;
    endfunction

    // Outputs are sampled 1 time unit after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("grant", 32'(grant), 32'(e.g));
            chk("valid", 32'(dv), 32'(e.v));
            if (e.v) chk("data", 32'(dout), 32'(e.d));
            if (e.g != 8'h00) chk("sel", 32'({s2, s1, s0}), 32'(oh2idx(e.g)));
`ifdef ARB_TURNAROUND_EN
            if (e.g != 8'h00) chk("busy", 32'(busy), 32'd1);
`else
            chk("busy", 32'(busy), 32'(e.g != 8'h00));
`endif
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic [7:0] r, input logic [W-1:0] y,
                        input logic [7:0] eg, input logic ev);
        req  = r;
        muxy = y;
        sbq.push_back('{g: eg, v: ev, d: y});
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Continuous request pattern: grants follow ord[], H beats each, GAP dead cycles between.
    task automatic rr_run(input logic [7:0] r, input int nsteps);
        int           p;
        int           k;
        logic [7:0]   eg;
        logic         ev;
        for (int s = 1; s <= nsteps; s++) begin
            p  = (s - 1) % P;
            k  = ((s - 1) / P) % ord_len;
            eg = (p < H) ? 8'(1 << ord[k]) : 8'h00;
            ev = (s >= 2) && ((GAP == 0) || (p != 0));
            step(r, W'($urandom), eg, ev);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        muxy  = '0;
        #12;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel", 32'({s2, s1, s0}), 32'h0);
        chk("rst_valid", 32'(dv), 32'h0);
        chk("rst_data", 32'(dout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single requester 3 held six cycles.
        step(8'h08, 16'hA5A5, 8'h08, 1'b0);
        step(8'h08, 16'hA5A5, 8'h08, 1'b1);
        step(8'h08, 16'hA5A5, 8'h08, 1'b1);
        step(8'h08, 16'hA5A5, 8'h08, 1'b1);
        step(8'h08, 16'hA5A5, (GAP != 0) ? 8'h00 : 8'h08, 1'b1);
        step(8'h08, 16'hA5A5, 8'h08, (GAP != 0) ? 1'b0 : 1'b1);
        step(8'h00, 16'h0000, 8'h00, 1'b0);
        step(8'h00, 16'h0000, 8'h00, 1'b0);

        // All requesters: rotation 0..7 then 0.
        do_reset();
        for (int i = 0; i < 8; i++) ord[i] = i;
        ord_len = 8;
        rr_run(8'hFF, 9 * P);

        // Requesters 0 and 5 alternate.
        do_reset();
        ord[0]  = 0;
        ord[1]  = 5;
        ord_len = 2;
        rr_run(8'h21, 3 * P);

        // Requester 2 drops after two beats while 6 waits.
        do_reset();
        step(8'h04, W'($urandom), 8'h04, 1'b0);
        step(8'h44, W'($urandom), 8'h04, 1'b1);
        step(8'h44, W'($urandom), 8'h04, 1'b1);
        step(8'h40, W'($urandom), (GAP != 0) ? 8'h00 : 8'h40, 1'b0);
        step(8'h40, W'($urandom), 8'h40, (GAP != 0) ? 1'b0 : 1'b1);
        step(8'h40, W'($urandom), 8'h40, 1'b1);
        step(8'h00, W'($urandom), 8'h00, 1'b0);
        step(8'h00, W'($urandom), 8'h00, 1'b0);

        // Reset asserted mid-cycle during the third beat of a grant to 3.
        do_reset();
        step(8'h18, W'($urandom), 8'h08, 1'b0);
        step(8'h18, W'($urandom), 8'h08, 1'b1);
        step(8'h18, W'($urandom), 8'h08, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_valid", 32'(dv), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_sel", 32'({s2, s1, s0}), 32'h0);
        chk("async_data", 32'(dout), 32'h0);
        @(posedge clk);
        #2;
        chk("inrst_valid", 32'(dv), 32'h0);
        chk("inrst_grant", 32'(grant), 32'h0);
        rst_n = 1'b1;
        step(8'h18, W'($urandom), 8'h08, 1'b0);
        step(8'h18, W'($urandom), 8'h08, 1'b1);
        do_reset();

        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_bus_arbiter.md
# mux_bus_arbiter

Round-robin arbiter and sequencer for the 16-bit, 8-to-1 select mux in the processor datapath. It shares the mux output bus between eight requesters. It drives the mux select lines {S2,S1,S0}, issues one-hot grants with a per-grant beat limit, and registers the selected mux output Y as a valid-qualified data beat.

## Interface
- WIDTH, 16: data width of the mux output captured by the block.
- HOLD_MAX, 4: maximum beats per grant, legal range 1–15.
- Clk  input  1  rising-edge clock; the block's only clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Req  input  8  request per mux input; bit i maps to mux input X(i+1).
- MuxY  input  WIDTH  mux output Y, fed back from the datapath.
- S2, S1, S0  output  1 each  registered mux select; {S2,S1,S0} is the granted index.
- Grant  output  8  registered one-hot grant; all zero when no grant is active.
- DataOut  output  WIDTH  registered copy of MuxY captured on each beat.
- DataValid  output  1  high for one cycle per captured beat.
- Busy  output  1  high while in the GRANT or TURN state.

## Operation
- States: IDLE, GRANT, TURN. TURN exists only with the configuration macro defined.
- Ptr (3 bits) holds the index of the last granted requester. Reset value is 7, so index 0 has first priority.
- Arbitration: the winner is the first set Req bit searching Ptr+1, Ptr+2, … modulo 8. On winning, Ptr takes the winner index.
- IDLE:
  - Grant = 0.
  - If any Req is set: arbitrate, load the select lines and Grant, clear BeatCnt, and go to GRANT.
- GRANT, with granted index g:
  - A cycle with Req[g]=1 is a beat. At that edge DataOut <= MuxY, DataValid <= 1, and BeatCnt increments.
  - Release condition: Req[g]=0 in a cycle (no beat that cycle), or a beat with BeatCnt == HOLD_MAX−1.
  - On release with the macro defined: go to TURN.
  - On release without the macro: re-arbitrate in the same cycle. A new winner is granted at that edge, and the same requester can win only if it is the sole one requesting. If Req is zero, go to IDLE.
- TURN: Grant = 0 for exactly one cycle, then behave as IDLE (arbitrate that cycle).
- DataValid is 0 in every cycle not immediately following a beat.
- The select lines hold their last value while no grant is active. They never change while Grant is nonzero.
- BeatCnt is 4 bits.
- Req bits for non-granted indices are ignored during GRANT and have no effect on the current grant.

## Timing
- Reset values (asynchronous, immediate): state IDLE, Grant=0, {S2,S1,S0}=0, DataOut=0, DataValid=0, Busy=0, Ptr=7, BeatCnt=0.
- Request to grant: Req sampled at edge n in IDLE gives Grant and select valid after edge n.
- Beat to data: a beat in cycle k gives DataOut and DataValid valid in cycle k+1.
- Maximum grant length: HOLD_MAX beat cycles. An unbroken request is forcibly released after HOLD_MAX beats.
- Switch gap between grants:
  - Without the macro, requester A's last Grant cycle is followed directly by requester B's.
  - With the macro, exactly one zero-Grant cycle separates them.
- Reset mid-grant: Grant and DataValid clear immediately. A partially counted burst is discarded, with no trailing DataValid.
- All eight Req set continuously: grants rotate 0,1,…,7,0. Each requester gets HOLD_MAX beats.

## Configuration
- ARB_TURNAROUND_EN:
  - Defined: the TURN state is compiled in, giving one dead bus cycle after every release. This is used when the downstream register file needs a turnaround cycle.
  - Undefined: TURN does not exist and the switch is back-to-back. Busy then equals |Grant.

## Test plan
- Reset with Req=8'h00 → Grant=0, {S2,S1,S0}=0, DataValid=0. Assert Reset_n mid-cycle → outputs clear without waiting for Clk.
- Req=8'h08 held 6 cycles, MuxY=16'hA5A5, HOLD_MAX=4:
  - Grant=8'h08 and select=3 one cycle later.
  - Exactly 4 DataValid pulses with DataOut=16'hA5A5.
  - Then release and regrant to index 3. There is a one-cycle gap if ARB_TURNAROUND_EN is defined.
- Req=8'hFF continuous → grant sequence 0..7,0. Each grant has HOLD_MAX beats, and the select lines match the Grant index.
- Req=8'h21 with Ptr=0, after a grant to 0 → next grant goes to index 5, then back to 0.
- Granted requester 2 drops Req after 2 beats while Req[6]=1 → exactly 2 DataValid pulses, then Grant=8'h40 (immediately, or after one zero cycle with the macro).
- Reset asserted during the 3rd beat of a grant → no further DataValid, Ptr=7, and the first grant after reset goes to the lowest requesting index.
